// File: rtl/tt_um_seq_adder.sv
// Sequential two-operand adder/subtractor/accumulator driven by a strobe pin.
// Operands arrive one byte per strobe; the result appears one cycle after the second.
module tt_um_seq_adder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GOT_A,
      S_CALC,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD,
      OP_SUB,
      OP_ACC
   } op_t;

   state_t     state;
   op_t        op;
   op_t        mode_op;
   logic       strobe_q;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [7:0] result_q;
   logic       carry_q;

   logic       strobe_evt;
   logic       clear_req;
   logic [1:0] mode;
   logic       acc_mode;
   logic [8:0] sum;
   logic       unused_uio;

   assign mode       = uio_in[3:2];
   assign acc_mode   = (mode == 2'b10);
   assign strobe_evt = uio_in[0] & ~strobe_q & ena;
   assign clear_req  = uio_in[1] & ena;
   assign unused_uio = &{1'b0, uio_in[7:4]};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      mode_op = OP_ADD;
      case (mode)
         2'b01:   mode_op = OP_SUB;
         2'b10:   mode_op = OP_ACC;
         default: mode_op = OP_ADD;
      endcase
   end

   // Bit 8 is the carry for add/accumulate and the borrow for subtract (9-bit wrap).
   always_comb begin
      sum = '0;
      case (op)
         OP_SUB:  sum = {1'b0, a_q} - {1'b0, b_q};
         OP_ACC:  sum = {1'b0, result_q} + {1'b0, b_q};
         default: sum = {1'b0, a_q} + {1'b0, b_q};
      endcase
   end

   // Edge detector runs every cycle regardless of ena so a held strobe never re-fires.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= uio_in[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         op       <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
      end else if (ena) begin
         if (clear_req) begin
            state    <= S_IDLE;
            op       <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (strobe_evt) begin
                     if (acc_mode) begin
                        a_q   <= result_q;
                        b_q   <= ui_in;
                        op    <= OP_ADD;
                        state <= S_CALC;
                     end else begin
                        a_q   <= ui_in;
                        state <= S_GOT_A;
                     end
                  end
               end
               S_GOT_A: begin
                  if (strobe_evt) begin
                     b_q   <= ui_in;
                     op    <= mode_op;
                     state <= S_CALC;
                  end
               end
               S_CALC: begin
                  result_q <= sum[7:0];
                  carry_q  <= sum[8];
                  state    <= S_DONE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign uo_out  = result_q;
   assign uio_out = {state == S_GOT_A, state == S_DONE, state == S_CALC, carry_q, 4'h0};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_seq_adder.sv
// Self-checking bench for tt_um_seq_adder: directed scenarios plus randomized
// operation sequences compared against an operation-level reference model.
module tb_tt_um_seq_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   // Reference model: operation-level view (pending first operand, last result).
   logic [7:0] m_result;
   logic [7:0] m_a;
   logic       m_carry;
   logic       m_have_a;
   logic       m_done;

   tt_um_seq_adder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] d, input logic stb, input logic clr,
                        input logic [1:0] md, input logic en);
      ui_in  = d;
      uio_in = {4'h0, md, clr, stb};
      ena    = en;
   endtask

   task automatic model_reset();
      m_result = 8'h00;
      m_a      = 8'h00;
      m_carry  = 1'b0;
      m_have_a = 1'b0;
      m_done   = 1'b0;
   endtask

   // Expected {uo_out, uio_out} once the design is settled between operations.
   function automatic logic [15:0] model_view();
      return {m_result, m_have_a, !m_have_a && m_done, 1'b0, m_carry, 4'h0};
   endfunction

   task automatic model_event(input logic [7:0] d, input logic [1:0] md);
      int total;
      if (!m_have_a && md == 2'b10) begin
         total    = int'(m_result) + int'(d);
         m_result = total[7:0];
         m_carry  = (total > 255);
         m_done   = 1'b1;
      end else if (!m_have_a) begin
         m_a      = d;
         m_have_a = 1'b1;
      end else begin
         if (md == 2'b01) begin
            total    = int'(m_a) - int'(d) + 256;
            m_result = total[7:0];
            m_carry  = (m_a < d);
         end else begin
            total    = int'(m_a) + int'(d);
            m_result = total[7:0];
            m_carry  = (total > 255);
         end
         m_have_a = 1'b0;
         m_done   = 1'b1;
      end
   endtask

   // One strobe pulse (high one cycle, low one cycle); mid is the view right after the event edge.
   task automatic strobe(input logic [7:0] d, input logic [1:0] md, output logic [15:0] mid);
      drive(d, 1'b1, 1'b0, md, 1'b1);
      tick();
      mid = {uo_out, uio_out};
      drive(d, 1'b0, 1'b0, md, 1'b1);
      tick();
      model_event(d, md);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ui_in  = 8'($urandom);
         uio_in = 8'($urandom);
         ena    = 1'($urandom);
         tick();
         checks++;
         if ({uo_out, uio_out, uio_oe} !== 24'h0000F0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %h expected 0000f0", i, {uo_out, uio_out, uio_oe});
         end
      end
      drive(8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      #2 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({uo_out, uio_out, uio_oe} !== 24'h0000F0) begin
            errors++;
            $display("FAIL reset_release[%0d]: got %h expected 0000f0", i, {uo_out, uio_out, uio_oe});
         end
      end
   endtask

   task automatic test_add();
      logic [15:0] mid;
      do_reset();
      strobe(8'd200, 2'b00, mid);
      checks++;
      if ({uo_out, uio_out} !== 16'h0080) begin
         errors++;
         $display("FAIL add_wait_b: got %h expected 0080", {uo_out, uio_out});
      end
      strobe(8'd100, 2'b00, mid);
      checks++;
      if (mid !== 16'h0020) begin
         errors++;
         $display("FAIL add_busy: got %h expected 0020", mid);
      end
      checks++;
      if ({uo_out, uio_out} !== 16'h2C50) begin
         errors++;
         $display("FAIL add_result: got %h expected 2c50", {uo_out, uio_out});
      end
   endtask

   task automatic test_sub();
      logic [15:0] mid;
      do_reset();
      strobe(8'd5, 2'b01, mid);
      strobe(8'd7, 2'b01, mid);
      checks++;
      if ({uo_out, uio_out} !== 16'hFE50) begin
         errors++;
         $display("FAIL sub_borrow: got %h expected fe50", {uo_out, uio_out});
      end
      strobe(8'd7, 2'b01, mid);
      checks++;
      if ({uo_out, uio_out} !== 16'hFE90) begin
         errors++;
         $display("FAIL sub_hold_in_got_a: got %h expected fe90", {uo_out, uio_out});
      end
      strobe(8'd5, 2'b01, mid);
      checks++;
      if ({uo_out, uio_out} !== 16'h0240) begin
         errors++;
         $display("FAIL sub_no_borrow: got %h expected 0240", {uo_out, uio_out});
      end
   endtask

   task automatic test_accumulate();
      logic [15:0] mid;
      logic [7:0]  data [3] = '{8'h10, 8'h20, 8'hF0};
      logic [15:0] want [3] = '{16'h1040, 16'h3040, 16'h2050};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         strobe(data[i], 2'b10, mid);
         checks++;
         if ({uo_out, uio_out} !== want[i]) begin
            errors++;
            $display("FAIL acc[%0d]: got %h expected %h", i, {uo_out, uio_out}, want[i]);
         end
      end
   endtask

   task automatic test_clear();
      logic [15:0] mid;
      do_reset();
      strobe(8'h80, 2'b00, mid);
      strobe(8'h90, 2'b00, mid);
      strobe(8'h33, 2'b00, mid);
      drive(8'h44, 1'b1, 1'b1, 2'b00, 1'b1);
      tick();
      checks++;
      if ({uo_out, uio_out} !== 16'h0000) begin
         errors++;
         $display("FAIL clear_priority: got %h expected 0000", {uo_out, uio_out});
      end
      drive(8'h44, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      model_reset();
      strobe(8'h55, 2'b00, mid);
      checks++;
      if (mid !== 16'h0080) begin
         errors++;
         $display("FAIL clear_next_is_a: got %h expected 0080", mid);
      end
      strobe(8'h01, 2'b00, mid);
      checks++;
      if ({uo_out, uio_out} !== 16'h5640) begin
         errors++;
         $display("FAIL clear_then_add: got %h expected 5640", {uo_out, uio_out});
      end
      // Clear while in CALC: the pending sum must never appear.
      strobe(8'h0F, 2'b00, mid);
      drive(8'h0F, 1'b1, 1'b0, 2'b00, 1'b1);
      tick();
      drive(8'h0F, 1'b0, 1'b1, 2'b00, 1'b1);
      tick();
      drive(8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      checks++;
      if ({uo_out, uio_out} !== 16'h0000) begin
         errors++;
         $display("FAIL clear_in_calc: got %h expected 0000", {uo_out, uio_out});
      end
      model_reset();
   endtask

   task automatic test_glitch_enable();
      logic [15:0] mid;
      do_reset();
      drive(8'h11, 1'b1, 1'b0, 2'b00, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({uo_out, uio_out} !== 16'h0080) begin
            errors++;
            $display("FAIL held_strobe[%0d]: got %h expected 0080", i, {uo_out, uio_out});
         end
      end
      drive(8'h11, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      drive(8'h99, 1'b1, 1'b0, 2'b00, 1'b0);
      tick();
      drive(8'h99, 1'b0, 1'b1, 2'b00, 1'b0);
      tick();
      drive(8'h99, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      checks++;
      if ({uo_out, uio_out} !== 16'h0080) begin
         errors++;
         $display("FAIL ena_low_ignored: got %h expected 0080", {uo_out, uio_out});
      end
      drive(8'h22, 1'b1, 1'b0, 2'b00, 1'b1);
      tick();
      drive(8'h22, 1'b0, 1'b0, 2'b00, 1'b0);
      tick();
      checks++;
      if ({uo_out, uio_out} !== 16'h0020) begin
         errors++;
         $display("FAIL calc_held_by_ena: got %h expected 0020", {uo_out, uio_out});
      end
      drive(8'h77, 1'b1, 1'b0, 2'b00, 1'b1);
      tick();
      drive(8'h77, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      checks++;
      if ({uo_out, uio_out} !== 16'h3340) begin
         errors++;
         $display("FAIL calc_strobe_dropped: got %h expected 3340", {uo_out, uio_out});
      end
      model_reset();
      m_result = 8'h33;
      m_done   = 1'b1;
      strobe(8'h01, 2'b00, mid);
      checks++;
      if ({uo_out, uio_out} !== 16'h3380) begin
         errors++;
         $display("FAIL after_drop_is_a: got %h expected 3380", {uo_out, uio_out});
      end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] mid;
      do_reset();
      strobe(8'h40, 2'b00, mid);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({uo_out, uio_out} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_in_got_a: got %h expected 0000", {uo_out, uio_out});
      end
      rst_n = 1'b1;
      tick();
      model_reset();
      strobe(8'h05, 2'b00, mid);
      checks++;
      if (mid !== 16'h0080) begin
         errors++;
         $display("FAIL reset_discards_a: got %h expected 0080", mid);
      end
      drive(8'h06, 1'b1, 1'b0, 2'b00, 1'b1);
      tick();
      #1 rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      drive(8'h06, 1'b0, 1'b0, 2'b00, 1'b1);
      tick();
      tick();
      checks++;
      if ({uo_out, uio_out} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_in_calc: got %h expected 0000", {uo_out, uio_out});
      end
      model_reset();
   endtask

   task automatic test_random();
      logic [15:0] mid;
      logic [15:0] exp_mid;
      logic [7:0]  d;
      logic [1:0]  md;
      int          kind;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 9);
         d    = 8'($urandom);
         md   = 2'($urandom);
         if (kind == 0) begin
            drive(d, 1'b0, 1'b1, md, 1'b1);
            tick();
            drive(d, 1'b0, 1'b0, md, 1'b1);
            tick();
            model_reset();
         end else if (kind == 1) begin
            drive(d, 1'b1, 1'b1, md, 1'b0);
            tick();
            drive(d, 1'b0, 1'b0, md, 1'b1);
            tick();
         end else begin
            if (m_have_a && md == 2'b10) md = 2'b01;
            if (m_have_a || md == 2'b10) exp_mid = {m_result, 3'b001, m_carry, 4'h0};
            else                         exp_mid = {m_result, 3'b100, m_carry, 4'h0};
            strobe(d, md, mid);
            checks++;
            if (mid !== exp_mid) begin
               errors++;
               $display("FAIL rand_mid[%0d]: got %h expected %h", i, mid, exp_mid);
            end
         end
         checks++;
         if ({uo_out, uio_out} !== model_view()) begin
            errors++;
            $display("FAIL rand_view[%0d]: got %h expected %h", i, {uo_out, uio_out}, model_view());
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
      model_reset();
      test_reset();
      test_add();
      test_sub();
      test_accumulate();
      test_clear();
      test_glitch_enable();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_um_seq_adder.md
TT_UM_SEQ_ADDER -- requirements
Module: tt_um_seq_adder

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ena  in  1  design selected; when 0, strobe events are ignored and all state holds.
REQ-005 ui_in  in  8  operand byte, sampled on a strobe event.
REQ-006 uio_in  in  8  [0] strobe, [1] clear, [3:2] mode (00 add, 01 sub, 10 accumulate, 11 = add); [7:4] ignored.
REQ-007 uo_out  out  8  registered result[7:0].
REQ-008 uio_out  out  8  [4] carry/borrow, [5] busy, [6] done, [7] wait_b; [3:0] driven 0.
REQ-009 uio_oe  out  8  constant 8'hF0.

Function
REQ-010 Strobe event = uio_in[0] & ~strobe_q & ena; strobe_q registers uio_in[0] every cycle, independent of ena.
REQ-011 A strobe held high for multiple cycles SHALL produce exactly one event.
REQ-012 FSM states: IDLE, GOT_A, CALC, DONE; encoding is free.
REQ-013 IDLE or DONE, event, mode != 10: A <= ui_in, state -> GOT_A, done -> 0.
REQ-014 IDLE or DONE, event, mode == 10: A <= result, B <= ui_in, op <= add, state -> CALC, done -> 0.
REQ-015 GOT_A, event: B <= ui_in, op <= mode latched at this event, state -> CALC.
REQ-016 CALC: one cycle; result <= op result, carry bit updated, state -> DONE.
REQ-017 Latency: B-capturing (or accumulate) event sampled at edge k -> result, carry and done=1 visible after edge k+1.
REQ-018 Add: {carry, result} = A + B, 9-bit.
REQ-019 Sub: result = (A - B) mod 256; carry = 1 iff A < B (borrow).
REQ-020 Accumulate: result = (result + B) mod 256; carry = bit 8 of that sum.
REQ-021 Events occurring while in CALC are dropped; no queuing.
REQ-022 busy = (state == CALC); wait_b = (state == GOT_A); done = (state == DONE); all derived from registered state.
REQ-023 result and carry hold their values through IDLE, GOT_A and DONE until the next CALC or clear.
REQ-024 clear (uio_in[1]=1, ena=1) is synchronous: A, B, result and carry <= 0, state -> IDLE; it takes priority over a simultaneous event, and that event is discarded.
REQ-025 clear while in CALC aborts the operation; result is not updated.
REQ-026 ena=0 in any state: FSM and data registers hold; clear is ignored.

Reset
REQ-027 rst_n=0 asynchronously forces state IDLE; A, B, result, carry and strobe_q to 0.
REQ-028 During and after reset, before any event: uo_out=8'h00, uio_out=8'h00, uio_oe=8'hF0.
REQ-029 Reset asserted mid-operation (GOT_A or CALC) discards the operation; no partial result is visible after release.

Verification
REQ-030 Reset: assert rst_n=0 with random inputs -> uo_out=00, uio_out=00, uio_oe=F0; after release these hold until an event.
REQ-031 Add: ena=1, mode 00, strobe ui_in=200, then strobe ui_in=100 -> wait_b=1 between strobes; busy=1 for one cycle; then uo_out=0x2C, carry=1, done=1.
REQ-032 Sub: mode 01, A=5, B=7 -> uo_out=0xFE, carry(borrow)=1; A=7, B=5 -> 0x02, carry=0.
REQ-033 Accumulate: from reset, mode 10, strobes 0x10, 0x20, 0xF0 -> uo_out 0x10, 0x30, 0x20 in turn; carry 0, 0, 1.
REQ-034 Clear priority: in GOT_A, assert clear and a strobe rising edge in the same cycle -> state IDLE, uo_out=00, done=0; the next strobe is captured as A.
REQ-035 Glitch and enable: strobe held high 5 cycles -> one capture only; strobes with ena=0 -> no state change; strobe during CALC -> dropped, result per REQ-016.
